// File: rtl/branch_resolve_queue_if.sv
// rtl/branch_resolve_queue_if.sv - predictor push, execute resolve and update/flush bundle
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int SUM_W = 9
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             push;
    logic [PC_W-1:0]  push_pc;
    logic [PC_W-1:0]  push_target;
    logic             push_pred;
    logic [SUM_W-1:0] push_sum;
    logic [1:0]       push_status;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [PC_W-1:0]  resolve_target;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic             upd_train;
    logic [1:0]       upd_status;
    logic [SUM_W-1:0] upd_sum;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;

    modport master (
        output push, push_pc, push_target, push_pred, push_sum, push_status,
        output resolve_valid, resolve_taken, resolve_target,
        input  full, empty, count,
        input  upd_valid, upd_pc, upd_taken, upd_train, upd_status, upd_sum,
        input  flush, redirect_pc
    );

    modport slave (
        input  push, push_pc, push_target, push_pred, push_sum, push_status,
        input  resolve_valid, resolve_taken, resolve_target,
        output full, empty, count,
        output upd_valid, upd_pc, upd_taken, upd_train, upd_status, upd_sum,
        output flush, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order queue of predicted branches with resolve/train/flush
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int SUM_W = 9,
    parameter int THETA = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_resolve_queue_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int SW1 = SUM_W + 1;
    localparam logic [SUM_W:0] THETA_V = SW1'(THETA);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PC_W-1:0]  pc_mem     [DEPTH];
    logic [PC_W-1:0]  target_mem [DEPTH];
    logic             pred_mem   [DEPTH];
    logic [SUM_W-1:0] sum_mem    [DEPTH];
    logic [1:0]       status_mem [DEPTH];

    logic [AW-1:0]    rd_idx, wr_idx;
    logic [PC_W-1:0]  h_pc, h_target, redirect_nxt;
    logic             h_pred;
    logic [SUM_W-1:0] h_sum;
    logic [1:0]       h_status;
    logic [SUM_W:0]   sum_ext, sum_abs;
    logic             pop, dir_mp, tgt_mp, mp, train, push_ok;

    assign rd_idx    = rd_ptr[AW-1:0];
    assign wr_idx    = wr_ptr[AW-1:0];
    assign bus.count = wr_ptr - rd_ptr;
    assign bus.empty = (wr_ptr == rd_ptr);
    assign bus.full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    always_comb begin
        h_pc     = pc_mem[rd_idx];
        h_target = target_mem[rd_idx];
        h_pred   = pred_mem[rd_idx];
        h_sum    = sum_mem[rd_idx];
        h_status = status_mem[rd_idx];

        pop    = bus.resolve_valid && !bus.empty;
        dir_mp = (bus.resolve_taken != h_pred);
        tgt_mp = bus.resolve_taken && h_pred && (bus.resolve_target != h_target);
        mp     = pop && (dir_mp || tgt_mp);

        // One extra bit so that |most negative sum| is representable
        sum_ext = {h_sum[SUM_W-1], h_sum};
        sum_abs = sum_ext[SUM_W] ? (~sum_ext + SW1'(1)) : sum_ext;
        train   = dir_mp || (sum_abs <= THETA_V);

        redirect_nxt = bus.resolve_taken ? bus.resolve_target : (h_pc + PC_W'(4));

        // A mispredicting pop squashes the whole wrong path, including this cycle's push
        push_ok = bus.push && !mp && (!bus.full || pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_idx]     <= bus.push_pc;
            target_mem[wr_idx] <= bus.push_target;
            pred_mem[wr_idx]   <= bus.push_pred;
            sum_mem[wr_idx]    <= bus.push_sum;
            status_mem[wr_idx] <= bus.push_status;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            bus.upd_valid   <= 1'b0;
            bus.upd_pc      <= '0;
            bus.upd_taken   <= 1'b0;
            bus.upd_train   <= 1'b0;
            bus.upd_status  <= '0;
            bus.upd_sum     <= '0;
            bus.flush       <= 1'b0;
            bus.redirect_pc <= '0;
        end else begin
            bus.upd_valid   <= pop;
            bus.flush       <= mp;
            bus.redirect_pc <= mp ? redirect_nxt : '0;
            if (pop) begin
                bus.upd_pc     <= h_pc;
                bus.upd_taken  <= bus.resolve_taken;
                bus.upd_train  <= train;
                bus.upd_status <= h_status;
                bus.upd_sum    <= h_sum;
            end
            if (mp) begin
                rd_ptr <= rd_ptr + PW'(1);
                wr_ptr <= rd_ptr + PW'(1);
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push_ok)
                    wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - randomized and directed bench for branch_resolve_queue
module tb_branch_resolve_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.DEPTH(4), .PC_W(32), .SUM_W(9)) bus ();
    branch_resolve_queue #(.DEPTH(4), .PC_W(32), .SUM_W(9), .THETA(14)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
        logic [8:0]  sum;
        logic [1:0]  status;
    } entry_t;

    entry_t      mq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        exp_upd_valid, exp_upd_taken, exp_upd_train, exp_flush;
    logic [31:0] exp_upd_pc, exp_redirect;
    logic [1:0]  exp_upd_status;
    logic [8:0]  exp_upd_sum;

    task automatic model_clear();
        mq.delete();
        exp_upd_valid = 0; exp_upd_taken = 0; exp_upd_train = 0; exp_flush = 0;
        exp_upd_pc = 0; exp_redirect = 0; exp_upd_status = 0; exp_upd_sum = 0;
    endtask

    // Applies one cycle of stimulus and advances the reference model alongside the DUT
    task automatic drive(input logic p, input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                         input logic [8:0] sum, input logic [1:0] st,
                         input logic rv, input logic rt, input logic [31:0] rtgt);
        entry_t h, e;
        int     s, size_before;
        logic   mp, pop;
        bus.push = p; bus.push_pc = pc; bus.push_target = tgt; bus.push_pred = pred;
        bus.push_sum = sum; bus.push_status = st;
        bus.resolve_valid = rv; bus.resolve_taken = rt; bus.resolve_target = rtgt;
        size_before = mq.size();
        pop = rv && (size_before > 0);
        mp = 0;
        exp_upd_valid = pop;
        exp_redirect = 0;
        if (pop) begin
            h = mq.pop_front();
            mp = (rt != h.pred) || (rt && h.pred && rtgt != h.target);
            s = $signed(h.sum);
            if (s < 0) s = -s;
            exp_upd_pc = h.pc; exp_upd_taken = rt; exp_upd_status = h.status; exp_upd_sum = h.sum;
            exp_upd_train = (rt != h.pred) || (s <= 14);
            if (mp) begin
                exp_redirect = rt ? rtgt : h.pc + 32'd4;
                mq.delete();
            end
        end
        exp_flush = mp;
        if (p && !mp && (size_before < 4 || pop)) begin
            e.pc = pc; e.target = tgt; e.pred = pred; e.sum = sum; e.status = st;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 0;
        model_clear();
        bus.push = 0; bus.push_pc = 0; bus.push_target = 0; bus.push_pred = 0; bus.push_sum = 0;
        bus.push_status = 0; bus.resolve_valid = 0; bus.resolve_taken = 0; bus.resolve_target = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.upd_valid !== 1'b0 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got %b%b want 00", bus.upd_valid, bus.flush); end
        n_cmp++; if (bus.redirect_pc !== 32'd0 || bus.upd_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pcs got %h/%h want 0/0", bus.redirect_pc, bus.upd_pc); end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) drive(1, 32'h10 + 4*i, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_full got full=%b count=%0d want 1/4", bus.full, bus.count); end
        drive(1, 32'h24, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_drop got count=%0d want 4", bus.count); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
            n_cmp++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h10 + 4*i || bus.flush !== 1'b0) begin n_fail++; $display("FAIL fill_drain got v=%b pc=%h fl=%b want 1/%h/0", bus.upd_valid, bus.upd_pc, bus.flush, 32'h10 + 4*i); end
        end
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_correct_taken();
        drive(1, 32'h20, 32'h40, 1, 9'sd30, 2'd1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h40);
        n_cmp++; if (bus.upd_valid !== 1'b1 || bus.upd_train !== 1'b0 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL correct_taken got v=%b tr=%b fl=%b want 1/0/0", bus.upd_valid, bus.upd_train, bus.flush); end
        n_cmp++; if (bus.upd_status !== 2'd1 || bus.upd_sum !== 9'd30 || bus.upd_taken !== 1'b1) begin n_fail++; $display("FAIL correct_fields got st=%0d sum=%0d tk=%b want 1/30/1", bus.upd_status, bus.upd_sum, bus.upd_taken); end
    endtask

    task automatic test_mispredict_flush();
        drive(1, 32'h20, 0, 0, -9'sd30, 0, 0, 0, 0);
        drive(1, 32'h24, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h28, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h80);
        n_cmp++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h80) begin n_fail++; $display("FAIL mp_flush got fl=%b rd=%h want 1/80", bus.flush, bus.redirect_pc); end
        n_cmp++; if (bus.upd_train !== 1'b1 || bus.count !== 3'd0) begin n_fail++; $display("FAIL mp_train_count got tr=%b cnt=%0d want 1/0", bus.upd_train, bus.count); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
            n_cmp++; if (bus.upd_valid !== 1'b0 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL mp_younger got v=%b fl=%b want 0/0", bus.upd_valid, bus.flush); end
        end
    endtask

    task automatic test_not_taken_mp();
        drive(1, 32'h30, 32'h40, 1, -9'sd100, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h34 || bus.upd_train !== 1'b1) begin n_fail++; $display("FAIL nt_mp got fl=%b rd=%h tr=%b want 1/34/1", bus.flush, bus.redirect_pc, bus.upd_train); end
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234);
        n_cmp++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h1234) begin n_fail++; $display("FAIL nt_taken_mp got fl=%b rd=%h want 1/1234", bus.flush, bus.redirect_pc); end
        drive(1, 32'hFFFF_FFFC, 32'h8, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (bus.redirect_pc !== 32'h0 || bus.flush !== 1'b1) begin n_fail++; $display("FAIL pc_wrap got rd=%h fl=%b want 0/1", bus.redirect_pc, bus.flush); end
    endtask

    task automatic test_theta();
        drive(1, 32'h50, 0, 0, 9'sd14, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (bus.upd_train !== 1'b1 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL theta_eq got tr=%b fl=%b want 1/0", bus.upd_train, bus.flush); end
        drive(1, 32'h54, 0, 0, 9'sd15, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (bus.upd_train !== 1'b0) begin n_fail++; $display("FAIL theta_above got tr=%b want 0", bus.upd_train); end
        drive(1, 32'h58, 0, 0, 9'h100, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (bus.upd_train !== 1'b0 || bus.upd_sum !== 9'h100) begin n_fail++; $display("FAIL theta_min got tr=%b sum=%h want 0/100", bus.upd_train, bus.upd_sum); end
        drive(1, 32'h5C, 32'h90, 1, 9'sd100, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'hA0);
        n_cmp++; if (bus.upd_train !== 1'b0 || bus.flush !== 1'b1 || bus.redirect_pc !== 32'hA0) begin n_fail++; $display("FAIL tgt_only got tr=%b fl=%b rd=%h want 0/1/a0", bus.upd_train, bus.flush, bus.redirect_pc); end
    endtask

    task automatic test_empty_resolve();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h99);
        n_cmp++; if (bus.upd_valid !== 1'b0 || bus.count !== 3'd0 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL empty_resolve got v=%b cnt=%0d fl=%b want 0/0/0", bus.upd_valid, bus.count, bus.flush); end
        drive(1, 32'h60, 0, 0, 0, 0, 1, 1, 32'h99);
        n_cmp++; if (bus.upd_valid !== 1'b0 || bus.count !== 3'd1) begin n_fail++; $display("FAIL empty_pushpop got v=%b cnt=%0d want 0/1", bus.upd_valid, bus.count); end
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (bus.upd_pc !== 32'h60 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL empty_drain got pc=%h e=%b want 60/1", bus.upd_pc, bus.empty); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drive(1, 32'h100 + 4*i, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h200 + 4*i, 0, 0, 0, 0, 1, 0, 0);
            n_cmp++; if (bus.count !== 3'd4 || bus.upd_pc !== 32'h100 + 4*i) begin n_fail++; $display("FAIL b2b_full got cnt=%0d pc=%h want 4/%h", bus.count, bus.upd_pc, 32'h100 + 4*i); end
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
            n_cmp++; if (bus.upd_pc !== 32'h200 + 4*i || bus.upd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_order got pc=%h v=%b want %h/1", bus.upd_pc, bus.upd_valid, 32'h200 + 4*i); end
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt, rtgt;
        for (int i = 0; i < 400; i++) begin
            tgt = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
            rtgt = ($urandom_range(0, 3) != 0 && mq.size() > 0) ? mq[0].target : 32'h1000 + 32'($urandom_range(0, 3)) * 4;
            drive($urandom_range(0, 2) != 0, 32'($urandom) & 32'hFFFF_FFFC, tgt, 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? 9'($urandom) : 9'($signed($urandom_range(0, 32)) - 16),
                  2'($urandom), $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1, ($urandom_range(0, 4) != 0) ? 1'b0 : 1'b1, rtgt);
            n_cmp++; if (bus.upd_valid !== exp_upd_valid || bus.flush !== exp_flush || bus.redirect_pc !== exp_redirect) begin n_fail++; $display("FAIL rand_strobe[%0d] got v=%b fl=%b rd=%h want %b/%b/%h", i, bus.upd_valid, bus.flush, bus.redirect_pc, exp_upd_valid, exp_flush, exp_redirect); end
            n_cmp++; if (bus.upd_pc !== exp_upd_pc || bus.upd_taken !== exp_upd_taken || bus.upd_train !== exp_upd_train || bus.upd_status !== exp_upd_status || bus.upd_sum !== exp_upd_sum) begin n_fail++; $display("FAIL rand_upd[%0d] got %h/%b/%b/%0d/%h want %h/%b/%b/%0d/%h", i, bus.upd_pc, bus.upd_taken, bus.upd_train, bus.upd_status, bus.upd_sum, exp_upd_pc, exp_upd_taken, exp_upd_train, exp_upd_status, exp_upd_sum); end
            n_cmp++; if (bus.count !== 3'(mq.size()) || bus.full !== (mq.size() == 4) || bus.empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rand_occ[%0d] got cnt=%0d f=%b e=%b want %0d", i, bus.count, bus.full, bus.empty, mq.size()); end
        end
    endtask

    task automatic test_reset_mid_flush();
        drive(1, 32'h70, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h74, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h300);
        n_cmp++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL rst_pre_flush got %b want 1", bus.flush); end
        rst = 0;
        #1;
        n_cmp++; if (bus.flush !== 1'b0 || bus.redirect_pc !== 32'd0 || bus.upd_valid !== 1'b0 || bus.upd_pc !== 32'd0 || bus.upd_train !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flush got fl=%b rd=%h v=%b pc=%h tr=%b want all 0", bus.flush, bus.redirect_pc, bus.upd_valid, bus.upd_pc, bus.upd_train); end
        n_cmp++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_occ got cnt=%0d e=%b want 0/1", bus.count, bus.empty); end
        model_clear();
        @(negedge clk);
        rst = 1;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_correct_taken();
        test_mispredict_flush();
        test_not_taken_mp();
        test_theta();
        test_empty_resolve();
        test_back_to_back();
        test_random();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
